// File: rtl/rr_arbiter_4.sv
// Four-requester arbiter with round-robin or fixed-priority selection, registered
// one-hot grants held while requested, and a hold-timeout that forces a release.
module rr_arbiter_4 #(
   parameter bit          MODE_RR  = 1'b1,
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam bit               HOLD_EN    = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

   state_t           state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       gnt_id_q, gnt_id_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [1:0]       last_id_q, last_id_d;
   logic [3:0]       mask_q, mask_d;
   logic [3:0]       cand_s;
   logic [2:0]       win_s;

   // Returns {found, index}; later loop iterations override earlier ones, so the
   // highest-priority candidate is visited last.
   function automatic logic [2:0] pick_winner(input logic [3:0] cand, input logic [1:0] last);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      if (MODE_RR) begin
         for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            res = cand[idx] ? {1'b1, idx} : res;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            res = cand[k] ? {1'b1, 2'(k)} : res;
         end
      end
      return res;
   endfunction

   assign cand_s = req & ~mask_q;
   assign win_s  = pick_winner(cand_s, last_id_q);

   // Next-state and next-output computation for the IDLE/BUSY controller.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;
      hold_cnt_d  = hold_cnt_q;
      last_id_d   = last_id_q;
      mask_d      = mask_q;
      case (state_q)
         IDLE: begin
            mask_d = 4'b0000;
            if (win_s[2]) begin
               state_d     = BUSY;
               gnt_d       = 4'b0001 << win_s[1:0];
               gnt_id_d    = win_s[1:0];
               gnt_valid_d = 1'b1;
               last_id_d   = win_s[1:0];
               hold_cnt_d  = CNT_ONE;
            end else begin
               gnt_d       = 4'b0000;
               gnt_id_d    = 2'd0;
               gnt_valid_d = 1'b0;
            end
         end
         BUSY: begin
            if (!req[gnt_id_q]) begin
               mask_d = 4'b0000;
               if (win_s[2]) begin
                  gnt_d       = 4'b0001 << win_s[1:0];
                  gnt_id_d    = win_s[1:0];
                  gnt_valid_d = 1'b1;
                  last_id_d   = win_s[1:0];
                  hold_cnt_d  = CNT_ONE;
               end else begin
                  state_d     = IDLE;
                  gnt_d       = 4'b0000;
                  gnt_id_d    = 2'd0;
                  gnt_valid_d = 1'b0;
                  hold_cnt_d  = CNT_ZERO;
               end
            end else if (HOLD_EN && (hold_cnt_q == MAX_HOLD_C)) begin
               // Forced release: the evicted owner sits out the next arbitration.
               state_d     = IDLE;
               gnt_d       = 4'b0000;
               gnt_id_d    = 2'd0;
               gnt_valid_d = 1'b0;
               timeout_d   = 1'b1;
               mask_d      = 4'b0001 << gnt_id_q;
               hold_cnt_d  = CNT_ZERO;
            end else if (hold_cnt_q != CNT_MAX) begin
               hold_cnt_d = hold_cnt_q + CNT_ONE;
            end else begin
               hold_cnt_d = hold_cnt_q;
            end
         end
         default: begin
            state_d     = IDLE;
            gnt_d       = 4'b0000;
            gnt_id_d    = 2'd0;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = CNT_ZERO;
            mask_d      = 4'b0000;
         end
      endcase
   end

   // State and registered outputs; async reset drops any grant at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= 4'b0000;
         gnt_id_q    <= 2'd0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         hold_cnt_q  <= CNT_ZERO;
         last_id_q   <= 2'd3;
         mask_q      <= 4'b0000;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
         hold_cnt_q  <= hold_cnt_d;
         last_id_q   <= last_id_d;
         mask_q      <= mask_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: three configurations share one request bus and are
// checked every cycle against a behavioural model, plus directed scenarios.
module tb_rr_arbiter_4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt_a [3];
   logic [1:0] gnt_id_a [3];
   logic       gnt_valid_a [3];
   logic       timeout_a [3];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // Instance 0: round robin, hold 4; 1: fixed priority, hold 4; 2: round robin, no timeout.
   rr_arbiter_4 #(.MODE_RR(1'b1), .MAX_HOLD(4), .CNT_W(5)) u_rr (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt_a[0]), .gnt_id(gnt_id_a[0]),
      .gnt_valid(gnt_valid_a[0]), .timeout(timeout_a[0]));
   rr_arbiter_4 #(.MODE_RR(1'b0), .MAX_HOLD(4), .CNT_W(5)) u_fp (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt_a[1]), .gnt_id(gnt_id_a[1]),
      .gnt_valid(gnt_valid_a[1]), .timeout(timeout_a[1]));
   rr_arbiter_4 #(.MODE_RR(1'b1), .MAX_HOLD(0), .CNT_W(5)) u_nt (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt_a[2]), .gnt_id(gnt_id_a[2]),
      .gnt_valid(gnt_valid_a[2]), .timeout(timeout_a[2]));

   typedef struct {
      bit       busy;
      int       owner;
      int       cnt;
      int       last;
      bit [3:0] mask;
      bit       tmo;
   } ms_t;

   ms_t m [3];

   function automatic bit mode_of(input int i);
      return (i != 1);
   endfunction

   function automatic int maxh_of(input int i);
      return (i == 2) ? 0 : 4;
   endfunction

   function automatic ms_t reset_state();
      ms_t s;
      s.busy = 0; s.owner = 0; s.cnt = 0; s.last = 3; s.mask = 4'b0000; s.tmo = 0;
      return s;
   endfunction

   // Scan candidates in the policy's order; -1 if nobody qualifies.
   function automatic int pick(input bit [3:0] cand, input bit mode, input int last);
      if (mode) begin
         for (int k = 1; k <= 4; k++) if (cand[(last + k) % 4]) return (last + k) % 4;
      end else begin
         for (int i = 3; i >= 0; i--) if (cand[i]) return i;
      end
      return -1;
   endfunction

   function automatic ms_t step(input ms_t s, input bit [3:0] r, input bit mode, input int maxh);
      ms_t n;
      int  w;
      n = s;
      n.tmo = 0;
      if (!s.busy || !r[s.owner]) begin
         w = pick(r & ~s.mask, mode, s.last);
         n.mask = 4'b0000;
         if (w >= 0) begin
            n.busy = 1; n.owner = w; n.last = w; n.cnt = 1;
         end else begin
            n.busy = 0; n.cnt = 0;
         end
      end else if (maxh != 0 && s.cnt == maxh) begin
         n.busy = 0; n.tmo = 1; n.cnt = 0;
         n.mask = 4'b0001 << s.owner;
      end else if (s.cnt < 31) begin
         n.cnt = s.cnt + 1;
      end
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) m[i] <= reset_state();
         else     m[i] <= step(m[i], req, mode_of(i), maxh_of(i));
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("gnt[%0d]", i), 32'(gnt_a[i]), m[i].busy ? (32'd1 << m[i].owner) : 32'd0);
         check($sformatf("gnt_id[%0d]", i), 32'(gnt_id_a[i]), m[i].busy ? 32'(m[i].owner) : 32'd0);
         check($sformatf("gnt_valid[%0d]", i), 32'(gnt_valid_a[i]), 32'(m[i].busy));
         check($sformatf("timeout[%0d]", i), 32'(timeout_a[i]), 32'(m[i].tmo));
      end
   endtask

   task automatic tick();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      // Reset with all requesting, then the first grant one cycle after release.
      req = 4'b1111;
      tick();
      check("rst_gnt", 32'(gnt_a[0]), 32'h0);
      check("rst_timeout", 32'(timeout_a[0]), 32'h0);
      rst = 1'b0;
      tick();
      check("first_gnt", 32'(gnt_a[0]), 32'h1);
      check("first_id", 32'(gnt_id_a[0]), 32'h0);

      // Round-robin rotation on the no-timeout instance: 3-cycle holds, then release.
      for (int k = 0; k < 5; k++) begin
         check("rot_gnt", 32'(gnt_a[2]), 32'd1 << (k % 4));
         tick();
         tick();
         req = 4'b1111 & ~(4'b0001 << (k % 4));
         tick();
         check("rot_nogap", 32'(gnt_valid_a[2]), 32'h1);
         req = 4'b1111;
      end

      // Fixed priority: 2 beats 1, a late req[3] waits for the owner to let go.
      do_reset();
      req = 4'b0110;
      tick();
      check("fp_first", 32'(gnt_a[1]), 32'h4);
      req = 4'b1110;
      tick();
      check("fp_hold", 32'(gnt_a[1]), 32'h4);
      tick();
      req = 4'b1010;
      tick();
      check("fp_next", 32'(gnt_a[1]), 32'h8);

      // Timeout with two requesters, then with a single requester.
      do_reset();
      req = 4'b0011;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("to_hold", 32'(gnt_a[0]), 32'h1);
      end
      tick();
      check("to_gap", 32'(gnt_a[0]), 32'h0);
      check("to_pulse", 32'(timeout_a[0]), 32'h1);
      tick();
      check("to_next", 32'(gnt_a[0]), 32'h2);
      check("to_pulse_end", 32'(timeout_a[0]), 32'h0);

      do_reset();
      req = 4'b0001;
      for (int k = 0; k < 4; k++) tick();
      tick();
      check("solo_pulse", 32'(timeout_a[0]), 32'h1);
      tick();
      check("solo_gap2", 32'(gnt_a[0]), 32'h0);
      tick();
      check("solo_regrant", 32'(gnt_a[0]), 32'h1);

      // Owner release on the cycle the hold limit is reached.
      do_reset();
      req = 4'b0011;
      for (int k = 0; k < 4; k++) tick();
      req = 4'b0010;
      tick();
      check("coin_gnt", 32'(gnt_a[0]), 32'h2);
      check("coin_timeout", 32'(timeout_a[0]), 32'h0);

      // Asynchronous reset between edges while instance 1 grants requester 2.
      do_reset();
      req = 4'b0100;
      tick();
      check("ar_pre", 32'(gnt_a[1]), 32'h4);
      #2 rst = 1'b1;
      #1;
      check("ar_drop", 32'(gnt_a[1]), 32'h0);
      check("ar_drop_to", 32'(timeout_a[1]), 32'h0);
      compare_all();
      @(negedge clk);
      rst = 1'b0;
      req = 4'b1111;
      tick();
      check("ar_after", 32'(gnt_a[0]), 32'h1);

      // Randomised traffic: sticky request bits with occasional resets.
      for (int c = 0; c < 4000; c++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
         end
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end else begin
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester arbiter that shares one downstream resource (e.g. a bus slot or shared datapath) between requesters.
- Selectable round-robin or fixed-priority policy. Fixed priority matches the team's 4-to-2 priority encoder ordering: req[3] highest, req[0] lowest.
- Grants are registered, held while the owner keeps its request, and bounded by a hold-timeout counter.
- Sits between requesting masters and the shared resource; gnt_id drives the resource mux select.

Parameters:
- MODE_RR, 1, 1 = round-robin rotation, 0 = fixed priority (3 > 2 > 1 > 0).
- MAX_HOLD, 16, maximum consecutive cycles one grant may stay asserted; 0 disables the timeout. Legal range 0..(2^CNT_W - 1).
- CNT_W, 5, width of the hold counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; requester i holds req[i] high for as long as it wants the resource.
- gnt  output  4  one-hot grant, registered; all zeros when no owner.
- gnt_id  output  2  index of current owner; 0 when gnt_valid = 0.
- gnt_valid  output  1  high whenever gnt is non-zero.
- timeout  output  1  one-cycle pulse on the cycle a forced release takes effect.

Behaviour:
- Reset, asynchronous, any state:
  - gnt = 0, gnt_id = 0, gnt_valid = 0, timeout = 0.
  - state = IDLE, hold_cnt = 0, last_id = 3, mask = 0.
  - Reset asserted mid-grant drops the grant immediately, with no timeout pulse.
- States: IDLE (no owner) and BUSY (owner = gnt_id).
- Candidate set = req & ~mask. mask is cleared after every arbitration decision.
- Winner selection:
  - MODE_RR = 1: search order starts at (last_id + 1) mod 4 and ascends with wrap-around.
  - MODE_RR = 0: 3, 2, 1, 0.
- IDLE:
  - If the candidate set is non-zero at a rising edge, register the winner: gnt[w] = 1, gnt_id = w, gnt_valid = 1, last_id = w, hold_cnt = 1, go BUSY.
  - Latency from req sampled high to gnt high is exactly 1 cycle.
  - If the candidate set is zero, stay IDLE with outputs 0.
- BUSY, evaluated each edge in this priority:
  1. req[gnt_id] low (owner release): re-arbitrate on the same edge among remaining candidates.
     - If a winner exists: new grant, hold_cnt = 1, stay BUSY. No dead cycle between owners.
     - If no winner: gnt = 0, go IDLE.
  2. MAX_HOLD != 0 and hold_cnt == MAX_HOLD with owner req still high (forced release):
     - gnt = 0, gnt_valid = 0, gnt_id = 0, timeout = 1 for this cycle.
     - mask = one-hot(owner), last_id unchanged, go IDLE.
     - The masked requester cannot win the next arbitration, in either mode.
  3. Otherwise hold the grant; hold_cnt increments and saturates at 2^CNT_W - 1.
- A grant is asserted for at most MAX_HOLD consecutive cycles. After a timeout, at least one cycle has gnt = 0.
- Requests are level-sensitive. Glitches on non-owner req bits while BUSY have no effect until the next arbitration.
- Simultaneous owner release and hold_cnt == MAX_HOLD: the release wins and no timeout pulse is generated.
- After a forced release, if only the masked requester is requesting, the next IDLE edge grants nothing. mask then clears, so the requester wins on the following edge.
- gnt is always one-hot or zero. gnt_valid == |gnt; gnt_id == encode(gnt).
- All outputs are registered; no combinational path from req to outputs.

Test Plan:
- Reset / first grant: rst high with req = 4'b1111 -> all outputs 0. Release rst, MODE_RR = 1 -> one cycle later gnt = 4'b0001, gnt_id = 0.
- Round-robin rotation: req = 4'b1111, each owner drops its req for one cycle after 3 cycles of grant. Grants follow 0, 1, 2, 3, 0 with no zero-grant cycle between owners.
- Fixed priority: MODE_RR = 0, req = 4'b0110 -> gnt = 4'b0100. Raise req[3] while 2 holds -> no change. Drop req[2] -> next cycle gnt = 4'b1000.
- Timeout: MAX_HOLD = 4, req = 4'b0011 held constant:
  - gnt = 4'b0001 for exactly 4 cycles.
  - Then one cycle with gnt = 0 and timeout = 1.
  - Then gnt = 4'b0010.
  - Repeat with only req[0] high: gap of 2 zero-grant cycles before req 0 is re-granted.
- Release and timeout coincide: MAX_HOLD = 4, owner drops req on the 4th grant cycle with req[1] pending -> gnt moves to 4'b0010 directly, timeout stays 0.
- Async reset mid-grant: assert rst between clock edges while gnt = 4'b0100 -> gnt = 0 immediately, before the next edge. After release, first winner is 0 (last_id = 3).
